// File: rtl/cache_miss_handler_if.sv
// Memory-side bus between the miss handler and the arbiter CORE port.
interface cache_miss_handler_if #(
   parameter int DATA_WIDTH         = 32,
   parameter int CORE_ADDRESS_WIDTH = 21
);
   logic                          o_MEM_Valid;
   logic                          o_MEM_Read_Write_n;
   logic [CORE_ADDRESS_WIDTH-1:0] o_MEM_Address;
   logic [DATA_WIDTH-1:0]         o_MEM_Data;
   logic                          i_MEM_Valid;
   logic                          i_MEM_Data_Read;
   logic                          i_MEM_Last;
   logic [DATA_WIDTH-1:0]         i_MEM_Data;

   modport master (
      output o_MEM_Valid, o_MEM_Read_Write_n, o_MEM_Address, o_MEM_Data,
      input  i_MEM_Valid, i_MEM_Data_Read, i_MEM_Last, i_MEM_Data
   );

   modport slave (
      input  o_MEM_Valid, o_MEM_Read_Write_n, o_MEM_Address, o_MEM_Data,
      output i_MEM_Valid, i_MEM_Data_Read, i_MEM_Last, i_MEM_Data
   );
endinterface

// File: rtl/cache_miss_handler.sv
// Line-miss engine: optional dirty-victim write burst, then line fill read burst.
//   state     | meaning
//   IDLE      | waiting for a miss
//   WRITEBACK | write burst of victim line
//   GAP       | one idle cycle between bursts
//   FILL      | read burst, words streamed into line RAM
//   DONE      | one-cycle completion pulse
module cache_miss_handler #(
   parameter int DATA_WIDTH         = 32,
   parameter int CORE_ADDRESS_WIDTH = 21,
   parameter int OFFSET_WIDTH       = 2
) (
   input  logic                                 i_Clk,
   input  logic                                 i_Reset_n,
   input  logic                                 i_Miss_Valid,
   input  logic [CORE_ADDRESS_WIDTH-OFFSET_WIDTH-1:0] i_Miss_Line_Address,
   input  logic                                 i_Victim_Dirty,
   input  logic [CORE_ADDRESS_WIDTH-OFFSET_WIDTH-1:0] i_Victim_Line_Address,
   output logic [OFFSET_WIDTH-1:0]              o_Victim_Read_Index,
   input  logic [DATA_WIDTH-1:0]                i_Victim_Data,
   output logic                                 o_Fill_Valid,
   output logic [OFFSET_WIDTH-1:0]              o_Fill_Index,
   output logic [DATA_WIDTH-1:0]                o_Fill_Data,
   output logic                                 o_Busy,
   output logic                                 o_Done,
   output logic                                 o_Burst_Error,
   cache_miss_handler_if.master                 mem
);
   localparam int LINE_AW = CORE_ADDRESS_WIDTH - OFFSET_WIDTH;
   localparam logic [OFFSET_WIDTH:0] LINE_BEATS = (OFFSET_WIDTH+1)'(2**OFFSET_WIDTH);
   localparam logic [OFFSET_WIDTH:0] BEATS_SAT  = LINE_BEATS + (OFFSET_WIDTH+1)'(1);

   typedef enum logic [2:0] {IDLE, WRITEBACK, GAP, FILL, DONE} state_t;

   state_t                  state_q, state_d;
   logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
   logic [OFFSET_WIDTH:0]   beats_q, beats_d;
   logic [OFFSET_WIDTH:0]   beats_inc, beats_after;
   logic [LINE_AW-1:0]      miss_line_q, miss_line_d;
   logic [LINE_AW-1:0]      victim_line_q, victim_line_d;
   logic                    fill_valid_q, fill_valid_d;
   logic [OFFSET_WIDTH-1:0] fill_index_q, fill_index_d;
   logic [DATA_WIDTH-1:0]   fill_data_q, fill_data_d;
   logic                    err_q, err_d;

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         beats_q       <= '0;
         miss_line_q   <= '0;
         victim_line_q <= '0;
         fill_valid_q  <= 1'b0;
         fill_index_q  <= '0;
         fill_data_q   <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         beats_q       <= beats_d;
         miss_line_q   <= miss_line_d;
         victim_line_q <= victim_line_d;
         fill_valid_q  <= fill_valid_d;
         fill_index_q  <= fill_index_d;
         fill_data_q   <= fill_data_d;
         err_q         <= err_d;
      end
   end

   // beats_q saturates past LINE_WORDS so repeated wraps of cnt still flag an error
   assign beats_inc = (beats_q == BEATS_SAT) ? beats_q : beats_q + (OFFSET_WIDTH+1)'(1);

   always_comb begin
      state_d                = state_q;
      cnt_d                  = cnt_q;
      beats_d                = beats_q;
      beats_after            = beats_q;
      miss_line_d            = miss_line_q;
      victim_line_d          = victim_line_q;
      fill_valid_d           = 1'b0;
      fill_index_d           = fill_index_q;
      fill_data_d            = fill_data_q;
      err_d                  = err_q;
      mem.o_MEM_Valid        = 1'b0;
      mem.o_MEM_Read_Write_n = 1'b1;
      mem.o_MEM_Address      = '0;
      mem.o_MEM_Data         = '0;
      o_Victim_Read_Index    = '0;

      case (state_q)
         IDLE: begin
            if (i_Miss_Valid) begin
               miss_line_d   = i_Miss_Line_Address;
               victim_line_d = i_Victim_Line_Address;
               cnt_d         = '0;
               beats_d       = '0;
               state_d       = i_Victim_Dirty ? WRITEBACK : FILL;
            end
         end
         WRITEBACK: begin
            mem.o_MEM_Valid        = 1'b1;
            mem.o_MEM_Read_Write_n = 1'b0;
            mem.o_MEM_Address      = {victim_line_q, {OFFSET_WIDTH{1'b0}}};
            mem.o_MEM_Data         = i_Victim_Data;
            o_Victim_Read_Index    = cnt_q;
            if (mem.i_MEM_Data_Read) begin
               cnt_d       = cnt_q + OFFSET_WIDTH'(1);
               beats_after = beats_inc;
               beats_d     = beats_inc;
            end
            if (mem.i_MEM_Last) begin
               if (beats_after != LINE_BEATS) err_d = 1'b1;
               cnt_d   = '0;
               beats_d = '0;
               state_d = GAP;
            end
         end
         GAP: state_d = FILL;
         FILL: begin
            mem.o_MEM_Valid        = 1'b1;
            mem.o_MEM_Read_Write_n = 1'b1;
            mem.o_MEM_Address      = {miss_line_q, {OFFSET_WIDTH{1'b0}}};
            if (mem.i_MEM_Valid) begin
               fill_valid_d = 1'b1;
               fill_index_d = cnt_q;
               fill_data_d  = mem.i_MEM_Data;
               cnt_d        = cnt_q + OFFSET_WIDTH'(1);
               beats_after  = beats_inc;
               beats_d      = beats_inc;
            end
            if (mem.i_MEM_Last) begin
               if (beats_after != LINE_BEATS) err_d = 1'b1;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign o_Fill_Valid  = fill_valid_q;
   assign o_Fill_Index  = fill_index_q;
   assign o_Fill_Data   = fill_data_q;
   assign o_Busy        = (state_q != IDLE);
   assign o_Done        = (state_q == DONE);
   assign o_Burst_Error = err_q;
endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench for cache_miss_handler: clean, dirty, back-to-back, reset, short-burst misses.
module tb_cache_miss_handler;
   logic        i_Clk = 1'b0;
   logic        i_Reset_n;
   logic        i_Miss_Valid;
   logic [18:0] i_Miss_Line_Address;
   logic        i_Victim_Dirty;
   logic [18:0] i_Victim_Line_Address;
   logic [1:0]  o_Victim_Read_Index;
   logic [31:0] i_Victim_Data;
   logic        o_Fill_Valid;
   logic [1:0]  o_Fill_Index;
   logic [31:0] o_Fill_Data;
   logic        o_Busy;
   logic        o_Done;
   logic        o_Burst_Error;

   logic [31:0] vic [4];
   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   int exp_done = 0;

   cache_miss_handler_if #(.DATA_WIDTH(32), .CORE_ADDRESS_WIDTH(21)) mem_if ();

   cache_miss_handler #(.DATA_WIDTH(32), .CORE_ADDRESS_WIDTH(21), .OFFSET_WIDTH(2)) dut (
      .i_Clk                 (i_Clk),
      .i_Reset_n             (i_Reset_n),
      .i_Miss_Valid          (i_Miss_Valid),
      .i_Miss_Line_Address   (i_Miss_Line_Address),
      .i_Victim_Dirty        (i_Victim_Dirty),
      .i_Victim_Line_Address (i_Victim_Line_Address),
      .o_Victim_Read_Index   (o_Victim_Read_Index),
      .i_Victim_Data         (i_Victim_Data),
      .o_Fill_Valid          (o_Fill_Valid),
      .o_Fill_Index          (o_Fill_Index),
      .o_Fill_Data           (o_Fill_Data),
      .o_Busy                (o_Busy),
      .o_Done                (o_Done),
      .o_Burst_Error         (o_Burst_Error),
      .mem                   (mem_if.master)
   );

   always #5 i_Clk = ~i_Clk;

   assign i_Victim_Data = vic[o_Victim_Read_Index];

   always @(posedge i_Clk) if (o_Done) done_cnt <= done_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_Clk);
      #1;
   endtask

   task automatic start_miss(input logic [18:0] line, input logic dirty, input logic [18:0] victim);
      i_Miss_Valid = 1'b1;
      i_Miss_Line_Address = line;
      i_Victim_Dirty = dirty;
      i_Victim_Line_Address = victim;
      step();
      i_Miss_Valid = 1'b0;
   endtask

   task automatic rd(input logic [31:0] d, input logic last, input int idx, input logic exp_dn);
      mem_if.i_MEM_Valid = 1'b1;
      mem_if.i_MEM_Data  = d;
      mem_if.i_MEM_Last  = last;
      step();
      mem_if.i_MEM_Valid = 1'b0;
      mem_if.i_MEM_Last  = 1'b0;
      chk("fill_valid", 32'(o_Fill_Valid), 32'd1);
      chk("fill_index", 32'(o_Fill_Index), 32'(idx));
      chk("fill_data", o_Fill_Data, d);
      chk("done", 32'(o_Done), 32'(exp_dn));
      if (last) chk("mem_valid_after_last", 32'(mem_if.o_MEM_Valid), 32'd0);
   endtask

   initial begin
      vic[0] = 32'hC0DE0000; vic[1] = 32'hC0DE0001; vic[2] = 32'hC0DE0002; vic[3] = 32'hC0DE0003;
      i_Reset_n = 1'b0;
      i_Miss_Valid = 1'b0;
      i_Miss_Line_Address = '0;
      i_Victim_Dirty = 1'b0;
      i_Victim_Line_Address = '0;
      mem_if.i_MEM_Valid = 1'b0;
      mem_if.i_MEM_Data_Read = 1'b0;
      mem_if.i_MEM_Last = 1'b0;
      mem_if.i_MEM_Data = '0;
      #2;
      chk("rst_busy", 32'(o_Busy), 32'd0);
      chk("rst_mem_valid", 32'(mem_if.o_MEM_Valid), 32'd0);
      chk("rst_done", 32'(o_Done), 32'd0);
      chk("rst_err", 32'(o_Burst_Error), 32'd0);
      chk("rst_fill_valid", 32'(o_Fill_Valid), 32'd0);
      chk("rst_fill_data", o_Fill_Data, 32'd0);
      step();
      i_Reset_n = 1'b1;
      step();

      // clean miss on line 0x1234
      start_miss(19'h1234, 1'b0, 19'h0);
      chk("clean_busy", 32'(o_Busy), 32'd1);
      chk("clean_mem_valid", 32'(mem_if.o_MEM_Valid), 32'd1);
      chk("clean_rw", 32'(mem_if.o_MEM_Read_Write_n), 32'd1);
      chk("clean_addr", 32'(mem_if.o_MEM_Address), 32'h48D0);
      for (int i = 0; i < 4; i++) rd(32'hA0 + 32'(i), i == 3, i, i == 3);
      exp_done++;
      chk("clean_done_busy", 32'(o_Busy), 32'd1);
      chk("clean_err", 32'(o_Burst_Error), 32'd0);
      step();
      chk("clean_idle_busy", 32'(o_Busy), 32'd0);
      chk("clean_idle_done", 32'(o_Done), 32'd0);
      chk("clean_idle_fill_valid", 32'(o_Fill_Valid), 32'd0);

      // dirty miss, memory accepts a write every other cycle
      start_miss(19'h0ABC, 1'b1, 19'h0010);
      chk("wb_mem_valid", 32'(mem_if.o_MEM_Valid), 32'd1);
      chk("wb_rw", 32'(mem_if.o_MEM_Read_Write_n), 32'd0);
      chk("wb_addr", 32'(mem_if.o_MEM_Address), 32'h40);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("wb_index", 32'(o_Victim_Read_Index), 32'(i));
         chk("wb_data", mem_if.o_MEM_Data, 32'hC0DE0000 + 32'(i));
         mem_if.i_MEM_Data_Read = 1'b1;
         mem_if.i_MEM_Last = (i == 3);
         step();
         mem_if.i_MEM_Data_Read = 1'b0;
         mem_if.i_MEM_Last = 1'b0;
      end
      chk("gap_mem_valid", 32'(mem_if.o_MEM_Valid), 32'd0);
      chk("gap_busy", 32'(o_Busy), 32'd1);
      mem_if.i_MEM_Valid = 1'b1;
      mem_if.i_MEM_Data = 32'hDEAD;
      step();
      mem_if.i_MEM_Valid = 1'b0;
      chk("gap_beat_ignored", 32'(o_Fill_Valid), 32'd0);
      chk("fill_mem_valid", 32'(mem_if.o_MEM_Valid), 32'd1);
      chk("fill_rw", 32'(mem_if.o_MEM_Read_Write_n), 32'd1);
      chk("fill_addr", 32'(mem_if.o_MEM_Address), 32'h2AF0);
      for (int i = 0; i < 4; i++) rd(32'hB0 + 32'(i), i == 3, i, i == 3);
      exp_done++;
      step();
      chk("dirty_done_count", 32'(done_cnt), 32'(exp_done));
      chk("dirty_err", 32'(o_Burst_Error), 32'd0);

      // beat in IDLE is ignored
      mem_if.i_MEM_Valid = 1'b1;
      step();
      mem_if.i_MEM_Valid = 1'b0;
      chk("idle_beat_fill_valid", 32'(o_Fill_Valid), 32'd0);
      chk("idle_beat_busy", 32'(o_Busy), 32'd0);

      // miss held high through two completions
      i_Miss_Valid = 1'b1;
      i_Miss_Line_Address = 19'h0005;
      i_Victim_Dirty = 1'b0;
      step();
      chk("b2b_busy1", 32'(o_Busy), 32'd1);
      for (int i = 0; i < 4; i++) rd(32'hC0 + 32'(i), i == 3, i, i == 3);
      exp_done++;
      step();
      chk("b2b_gap_busy", 32'(o_Busy), 32'd0);
      step();
      i_Miss_Valid = 1'b0;
      chk("b2b_busy2", 32'(o_Busy), 32'd1);
      chk("b2b_mem_valid2", 32'(mem_if.o_MEM_Valid), 32'd1);
      for (int i = 0; i < 4; i++) rd(32'hD0 + 32'(i), i == 3, i, i == 3);
      exp_done++;
      step();
      chk("b2b_done_count", 32'(done_cnt), 32'(exp_done));

      // reset in the middle of a fill
      start_miss(19'h0100, 1'b0, 19'h0);
      rd(32'hE0, 1'b0, 0, 1'b0);
      rd(32'hE1, 1'b0, 1, 1'b0);
      #2;
      i_Reset_n = 1'b0;
      #1;
      chk("rst_mid_mem_valid", 32'(mem_if.o_MEM_Valid), 32'd0);
      chk("rst_mid_busy", 32'(o_Busy), 32'd0);
      chk("rst_mid_fill_valid", 32'(o_Fill_Valid), 32'd0);
      step();
      i_Reset_n = 1'b1;
      step();
      chk("rst_mid_no_done", 32'(done_cnt), 32'(exp_done));
      start_miss(19'h0200, 1'b0, 19'h0);
      chk("restart_addr", 32'(mem_if.o_MEM_Address), 32'h0800);
      for (int i = 0; i < 4; i++) rd(32'hF0 + 32'(i), i == 3, i, i == 3);
      exp_done++;
      step();

      // short burst: Last on the third beat
      start_miss(19'h0300, 1'b0, 19'h0);
      rd(32'h11, 1'b0, 0, 1'b0);
      rd(32'h12, 1'b0, 1, 1'b0);
      rd(32'h13, 1'b1, 2, 1'b1);
      exp_done++;
      chk("short_err", 32'(o_Burst_Error), 32'd1);
      step();
      start_miss(19'h0301, 1'b0, 19'h0);
      for (int i = 0; i < 4; i++) rd(32'h20 + 32'(i), i == 3, i, i == 3);
      exp_done++;
      step();
      chk("sticky_err", 32'(o_Burst_Error), 32'd1);
      chk("final_done_count", 32'(done_cnt), 32'(exp_done));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/cache_miss_handler.md
# cache_miss_handler

Line-miss engine between the instruction/data cache and the CORE port of the memory arbiter. On a miss it optionally writes back a dirty victim line as one write burst, then fetches the missing line as one read burst and streams each returned word into the cache line RAM. It holds each request to the arbiter until the arbiter signals the last beat, then reports completion to the cache.

## Interface
- DATA_WIDTH, 32, word width on all data paths
- CORE_ADDRESS_WIDTH, 21, word address width of the arbiter CORE port
- OFFSET_WIDTH, 2, log2 of words per line; LINE_WORDS = 2**OFFSET_WIDTH
- i_Clk  in  1  clock
- i_Reset_n  in  1  asynchronous, active-low reset
- i_Miss_Valid  in  1  miss request; sampled only in IDLE
- i_Miss_Line_Address  in  CORE_ADDRESS_WIDTH-OFFSET_WIDTH  line to fetch
- i_Victim_Dirty  in  1  victim line needs writeback
- i_Victim_Line_Address  in  CORE_ADDRESS_WIDTH-OFFSET_WIDTH  victim line address
- o_Victim_Read_Index  out  OFFSET_WIDTH  victim word select (combinational read)
- i_Victim_Data  in  DATA_WIDTH  victim word at o_Victim_Read_Index, same cycle
- o_Fill_Valid  out  1  write o_Fill_Data into line RAM at o_Fill_Index
- o_Fill_Index  out  OFFSET_WIDTH  fill word offset
- o_Fill_Data  out  DATA_WIDTH  fill word
- o_Busy  out  1  state != IDLE
- o_Done  out  1  one-cycle completion pulse
- o_Burst_Error  out  1  sticky: a burst ended with the wrong beat count
- o_MEM_Valid  out  1  to arbiter i_CORE_Valid
- o_MEM_Read_Write_n  out  1  1 = read, 0 = write
- o_MEM_Address  out  CORE_ADDRESS_WIDTH  {line address, OFFSET_WIDTH zeros}
- o_MEM_Data  out  DATA_WIDTH  write data
- i_MEM_Valid  in  1  read beat valid
- i_MEM_Data_Read  in  1  write beat consumed this edge
- i_MEM_Last  in  1  final beat of current burst
- i_MEM_Data  in  DATA_WIDTH  read data

## Operation
- States: IDLE, WRITEBACK, GAP, FILL, DONE. Beat counter `cnt` is OFFSET_WIDTH bits wide.
- IDLE: when i_Miss_Valid is high, latch both line addresses and dirty, and clear cnt. Go to WRITEBACK if dirty, else FILL.
- WRITEBACK:
  - o_MEM_Valid=1, o_MEM_Read_Write_n=0, o_MEM_Address={victim line, 0}.
  - o_Victim_Read_Index=cnt and o_MEM_Data=i_Victim_Data, both combinational.
  - cnt increments on each i_MEM_Data_Read.
  - On i_MEM_Last: check beat count (see below), clear cnt, go to GAP.
- GAP: o_MEM_Valid=0 for exactly one cycle, which gives the arbiter a clean request boundary. Then go to FILL.
- FILL:
  - o_MEM_Valid=1, o_MEM_Read_Write_n=1, o_MEM_Address={miss line, 0}.
  - On each i_MEM_Valid: register o_Fill_Valid=1, o_Fill_Index=cnt, o_Fill_Data=i_MEM_Data, then increment cnt.
  - On i_MEM_Last: check beat count, go to DONE.
- DONE: o_Done=1 for one cycle, then go to IDLE.
- Beat-count check: on the Last edge, the counted beats including that edge must equal LINE_WORDS. Otherwise set o_Burst_Error. It stays set until reset, and the sequence still completes normally.
- cnt wraps modulo LINE_WORDS. Beats beyond LINE_WORDS overwrite from offset 0 and also raise the error.
- When not in WRITEBACK/FILL: o_MEM_Valid=0, o_MEM_Read_Write_n=1, o_MEM_Address=0, o_MEM_Data=0, o_Victim_Read_Index=0.

## Timing
- Reset values:
  - State IDLE, cnt 0.
  - o_Fill_Valid=0, o_Fill_Index=0, o_Fill_Data=0.
  - o_Done=0, o_Busy=0, o_Burst_Error=0, o_MEM_Valid=0.
- Because reset is asynchronous, o_MEM_Valid drops in the same cycle even mid-burst. No partial fill is reported as done.
- Miss accepted at edge N: o_MEM_Valid is high from cycle N+1. o_Busy is high from N+1.
- Fill latency: read beat at edge K produces o_Fill_Valid high during cycle K+1 (registered).
- After the FILL Last edge L:
  - o_MEM_Valid is low in cycle L+1.
  - The last o_Fill_Valid and o_Done are both high in cycle L+1.
  - o_Busy is low from L+2.
- Dirty sequence: WRITEBACK Last edge W, GAP cycle W+1, FILL request from W+2.
- i_Miss_Valid while busy is ignored. If it is still high in IDLE after DONE, it starts a new miss, so back-to-back misses have a 2-cycle minimum spacing between requests.
- i_MEM_Valid or i_MEM_Data_Read outside the matching state is ignored.
- i_MEM_Last and a data beat on the same edge: the beat counts first, then the transition happens.

## Test plan
- Clean miss, line 0x1234, LINE_WORDS=4, reads A0..A3 with Last on A3:
  - o_MEM_Address=0x48D0, Read_Write_n=1.
  - Fill writes (0,A0)..(3,A3).
  - o_Done pulses together with the last fill. o_Burst_Error=0.
- Dirty miss, victim 0x0010 holding V0..V3, memory accepts one word every other cycle:
  - Writes V0..V3 to 0x0040.
  - One-cycle o_MEM_Valid gap.
  - Fill from the miss line. One o_Done.
- i_Miss_Valid held high through two completions: two full sequences with o_Busy low for exactly one cycle between them.
- Reset asserted after 2 fill beats: o_MEM_Valid and o_Busy drop immediately. No o_Done. A subsequent miss restarts at offset 0.
- Last on the 3rd read beat: o_Burst_Error=1 and o_Done pulses. The next clean miss leaves o_Burst_Error=1.
- i_MEM_Valid pulses while in IDLE and GAP: no o_Fill_Valid, cnt unchanged.
